pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_if.sv | 22 ++
 rtl/pipe_skid_reg.sv | 87 ++++++++
 tb/tb_pipe_skid_reg.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg: upstream (valid_in/data_in/ready_out)
// and downstream (valid_out/data_out/ready_in) sides of one pipeline stage.
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_out;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              ready_in;

  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, valid_out, data_out
  );

  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register: ready_out is decoupled from ready_in so that
// upstream timing never sees the downstream ready path.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W   = 64,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rstn,
  input  logic                 flush,
  input  logic                 suspend,
  pipe_skid_reg_if.slave       bus,
  output logic [1:0]           occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] skid_r;
  logic              ready_out_s;
  logic              valid_out_s;
  logic              in_fire_s;
  logic              out_fire_s;

  assign ready_out_s = (state_r != ST_SKID) & ~suspend;
  assign valid_out_s = (state_r != ST_EMPTY) & ~suspend;
  // Both fires are already blocked by suspend through ready/valid; flush gates them on top.
  assign in_fire_s   = bus.valid_in & ready_out_s & ~flush;
  assign out_fire_s  = valid_out_s & bus.ready_in & ~flush;

  assign bus.ready_out = ready_out_s;
  assign bus.valid_out = valid_out_s;
  assign bus.data_out  = main_r;

  // Occupancy decode from the registered state
  always_comb begin
    occupancy = 2'd0;
    case (state_r)
      ST_EMPTY: occupancy = 2'd0;
      ST_FULL:  occupancy = 2'd1;
      ST_SKID:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  // Stage state and data registers; flush empties the stage but leaves payloads untouched
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_r <= ST_EMPTY;
      main_r  <= RST_DATA;
      skid_r  <= RST_DATA;
    end else if (flush) begin
      state_r <= ST_EMPTY;
    end else if (!suspend) begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            main_r  <= bus.data_in;
            state_r <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire_s && out_fire_s) begin
            main_r  <= bus.data_in;
          end else if (in_fire_s) begin
            skid_r  <= bus.data_in;
            state_r <= ST_SKID;
          end else if (out_fire_s) begin
            state_r <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire_s) begin
            main_r  <= skid_r;
            state_r <= ST_FULL;
          end
        end
        default: state_r <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: three widths (32, 1, 256) share one control stream and are
// checked every cycle against a capacity-2 FIFO queue model, plus directed scenarios.
module tb_pipe_skid_reg;

  localparam logic [31:0]  RST32  = 32'hDEAD_BEEF;
  localparam logic [0:0]   RST1   = 1'b1;
  localparam logic [255:0] RST256 = {8{32'hC0FF_EE11}};

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic         suspend;
  logic         valid_in;
  logic         ready_in;
  logic [31:0]  d32;
  logic [0:0]   d1;
  logic [255:0] d256;
  logic [1:0]   occ32, occ1, occ256;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.DATA_W(32))  b32 ();
  pipe_skid_reg_if #(.DATA_W(1))   b1 ();
  pipe_skid_reg_if #(.DATA_W(256)) b256 ();

  assign b32.valid_in  = valid_in;
  assign b32.data_in   = d32;
  assign b32.ready_in  = ready_in;
  assign b1.valid_in   = valid_in;
  assign b1.data_in    = d1;
  assign b1.ready_in   = ready_in;
  assign b256.valid_in = valid_in;
  assign b256.data_in  = d256;
  assign b256.ready_in = ready_in;

  pipe_skid_reg #(.DATA_W(32), .RST_DATA(RST32)) u32 (
    .cpu_clk(clk), .cpu_rstn(rstn), .flush(flush), .suspend(suspend),
    .bus(b32), .occupancy(occ32));
  pipe_skid_reg #(.DATA_W(1), .RST_DATA(RST1)) u1 (
    .cpu_clk(clk), .cpu_rstn(rstn), .flush(flush), .suspend(suspend),
    .bus(b1), .occupancy(occ1));
  pipe_skid_reg #(.DATA_W(256), .RST_DATA(RST256)) u256 (
    .cpu_clk(clk), .cpu_rstn(rstn), .flush(flush), .suspend(suspend),
    .bus(b256), .occupancy(occ256));

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of at most two entries per width, plus the
  // value last shown at the front (what data_out keeps once the stage drains).
  logic [255:0] q32[$];
  logic [255:0] q1[$];
  logic [255:0] q256[$];
  logic [255:0] sh32, sh1, sh256;
  int           m_n;
  bit           m_in, m_out;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        q32.delete(); q1.delete(); q256.delete();
        sh32 = 256'(RST32); sh1 = 256'(RST1); sh256 = RST256;
      end else begin
        m_n   = q32.size();
        m_in  = valid_in && (m_n < 2) && !suspend && !flush;
        m_out = (m_n > 0) && !suspend && ready_in && !flush;
        if (flush) begin
          q32.delete(); q1.delete(); q256.delete();
        end else begin
          if (m_out) begin
            void'(q32.pop_front()); void'(q1.pop_front()); void'(q256.pop_front());
          end
          if (m_in) begin
            q32.push_back(256'(d32)); q1.push_back(256'(d1)); q256.push_back(d256);
          end
        end
        if (q32.size() > 0) begin
          sh32 = q32[0]; sh1 = q1[0]; sh256 = q256[0];
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model, away from the active edge
  int  e_n;
  bit  e_v, e_r;
  initial begin
    forever begin
      @(negedge clk);
      e_n = q32.size();
      e_v = (e_n > 0) && !suspend;
      e_r = (e_n < 2) && !suspend;
      chk("occ32",   256'(occ32),  256'(e_n));
      chk("occ1",    256'(occ1),   256'(e_n));
      chk("occ256",  256'(occ256), 256'(e_n));
      chk("valid32", 256'(b32.valid_out),  256'(e_v));
      chk("valid1",  256'(b1.valid_out),   256'(e_v));
      chk("valid256",256'(b256.valid_out), 256'(e_v));
      chk("ready32", 256'(b32.ready_out),  256'(e_r));
      chk("ready1",  256'(b1.ready_out),   256'(e_r));
      chk("ready256",256'(b256.ready_out), 256'(e_r));
      chk("data32",  256'(b32.data_out), sh32);
      chk("data1",   256'(b1.data_out),  sh1);
      chk("data256", b256.data_out,      sh256);
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic r,
                       input logic f, input logic s);
    valid_in = v;
    d32      = d;
    d1       = d[0];
    d256     = {8{d}};
    ready_in = r;
    flush    = f;
    suspend  = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occ",   256'(occ32), 256'd0);
    chk("rst_valid", 256'(b32.valid_out), 256'd0);
    chk("rst_ready", 256'(b32.ready_out), 256'd1);
    chk("rst_data",  256'(b32.data_out), 256'(RST32));
    chk("rst_data256", b256.data_out, RST256);
    suspend = 1'b1;
    #1;
    chk("rst_ready_susp", 256'(b32.ready_out), 256'd0);
    suspend = 1'b0;

    // Streaming: first push lands on the first edge after reset release
    rstn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 32'(k), 1'b1, 1'b0, 1'b0);
      step();
      chk("stream_data",  256'(b32.data_out), 256'(k));
      chk("stream_occ",   256'(occ32), 256'd1);
      chk("stream_ready", 256'(b32.ready_out), 256'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("drain_occ",  256'(occ32), 256'd0);
    chk("drain_keep", 256'(b32.data_out), 256'h8);

    // Backpressure
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step();
    chk("bp_occ",   256'(occ32), 256'd2);
    chk("bp_ready", 256'(b32.ready_out), 256'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("bp_first", 256'(b32.data_out), 256'hA);
    step();
    chk("bp_second", 256'(b32.data_out), 256'hB);
    chk("bp_ready1", 256'(b32.ready_out), 256'd1);
    step();
    chk("bp_empty", 256'(occ32), 256'd0);

    // Flush from SKID with a simultaneous offer
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    step();
    chk("fl_occ",   256'(occ32), 256'd0);
    chk("fl_valid", 256'(b32.valid_out), 256'd0);
    chk("fl_data",  256'(b32.data_out), 256'hA);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) begin
      step();
      chk("fl_novalid", 256'(b32.valid_out), 256'd0);
    end

    // Suspend while FULL
    drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    step();
    repeat (3) begin
      drive(1'b1, 32'h66, 1'b1, 1'b0, 1'b1);
      step();
      chk("sus_valid", 256'(b32.valid_out), 256'd0);
      chk("sus_ready", 256'(b32.ready_out), 256'd0);
      chk("sus_occ",   256'(occ32), 256'd1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("sus_rel_valid", 256'(b32.valid_out), 256'd1);
    chk("sus_rel_data",  256'(b32.data_out), 256'h55);
    step();
    chk("sus_rel_occ", 256'(occ32), 256'd0);

    // Asynchronous reset mid-cycle in SKID
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    step();
    chk("ar_occ2", 256'(occ32), 256'd2);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid",   256'(b32.valid_out), 256'd0);
    chk("ar_data",    256'(b32.data_out), 256'(RST32));
    chk("ar_data256", b256.data_out, RST256);
    chk("ar_occ",     256'(occ32), 256'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Randomised traffic
    for (int i = 0; i < 10000; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      ready_in = ($urandom_range(0, 2) != 0);
      suspend  = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      d32      = $urandom;
      d1       = 1'($urandom);
      for (int w = 0; w < 8; w++) d256[w*32 +: 32] = $urandom;
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
